spi_cmd_ctrl: RTL and testbench
===============================

Name: spi_cmd_ctrl

Overview:
- Command sequencer between the SPI byte layer (bit shifter and SSEL/SCK synchroniser) and the two 8-bit byte FIFOs: host→core ("ingress") and core→host ("egress").
- Decodes the opcode byte at the start of each SSEL frame, then a length byte, then moves payload bytes.
- Selects the next MISO byte; pushes to the ingress FIFO and pops from the egress FIFO.
- Keeps the shifter free of protocol logic.

Parameters:
- LEN_W, 8, width of the length field and the byte counter.
- FILL_BYTE, 8'h00, byte sent on MISO when no data is available.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- sel_active  in  1  synchronised SSEL asserted (frame in progress)
- byte_vld  in  1  one-cycle pulse: a complete MOSI byte was received
- byte_rx  in  8  received MOSI byte; valid when byte_vld=1
- byte_tx  out  8  byte the shifter loads at the next frame-byte boundary
- ing_data  out  8  data into the ingress FIFO
- ing_push  out  1  ingress FIFO write enable (one-cycle pulse)
- ing_avail  in  8  free entries in the ingress FIFO
- egr_data  in  8  head of the egress FIFO (first-word fall-through); valid when egr_count≠0
- egr_pop  out  1  egress FIFO read enable (one-cycle pulse)
- egr_count  in  8  occupied entries in the egress FIFO
- ovf_flag  out  1  sticky: a write payload byte was dropped
- udf_flag  out  1  sticky: a read payload byte was fill data
- busy  out  1  state ≠ IDLE

Behaviour:
- Opcodes: STATUS=8'h81, READ=8'h82, WRITE=8'h04.
- States: IDLE, STAT0, STAT1, RLEN, RDATA, WLEN, WDATA, ERR.
- All actions occur only on cycles where byte_vld=1 and sel_active=1, and register in that same cycle (1-cycle latency). byte_tx is therefore stable at least 1 clk after byte_vld, well before the next SCK falling edge.
- Reset values:
  - byte_tx=FILL_BYTE, ing_push=0, egr_pop=0, ing_data=0
  - ovf_flag=0, udf_flag=0, state=IDLE, remaining=0
- IDLE, on byte_vld:
  - 81 → STAT0: byte_tx<=ing_avail.
  - 82 → RLEN.
  - 04 → WLEN.
  - Any other value → ERR, byte_tx<=FILL_BYTE.
- STAT0, on byte_vld → STAT1: byte_tx<=egr_count.
- STAT1, on byte_vld → IDLE: byte_tx<=FILL_BYTE. A further opcode may follow in the same frame.
- RLEN, on byte_vld (length N=byte_rx):
  - N=0 → IDLE.
  - Otherwise remaining<=N and → RDATA. Prefetch:
    - If egr_count≠0: byte_tx<=egr_data, egr_pop=1.
    - Else: byte_tx<=FILL_BYTE, udf_flag<=1.
- RDATA, on byte_vld (the previously loaded byte has just been shifted out):
  - remaining decrements.
  - If remaining was >1: prefetch the next byte with the same rule as RLEN.
  - If remaining was 1: byte_tx<=FILL_BYTE, → IDLE.
  - Exactly N pops occur for N bytes, fewer if an underrun occurs. A pop never happens with egr_count=0.
- WLEN, on byte_vld (length N=byte_rx):
  - N=0 → IDLE.
  - Otherwise remaining<=N and → WDATA.
- WDATA, on byte_vld:
  - If ing_avail≠0: ing_data<=byte_rx, ing_push=1.
  - Else: byte dropped, ovf_flag<=1.
  - remaining decrements; remaining reaching 0 → IDLE.
- ERR: ignores all bytes until the frame ends.
- Frame end: on any cycle with sel_active=0, the next cycle gives state=IDLE, remaining=0, byte_tx=FILL_BYTE, with no push or pop. This holds even if byte_vld=1 in that same cycle, so an aborted transfer is dropped.
- Sticky flags are cleared only by reset or by a STATUS opcode. On the STATUS opcode cycle the flags are cleared after being folded into status bit reporting: bit7 of the STAT1 byte = ovf|udf. If so, egr_count is saturated to 7 bits.
- ing_push and egr_pop are never asserted in the same cycle.
- Counter width: remaining is LEN_W bits. N=255 is legal and must not wrap.

Optional Feature:
- Macro SPI_CMD_STATS_EN.
- Defined:
  - Adds two 8-bit saturating counters: ovf_cnt (dropped write bytes) and udf_cnt (fill bytes sent).
  - Adds opcode 8'h83 STATS, which returns ovf_cnt then udf_cnt using STAT0/STAT1-style states.
  - Both counters clear after the second byte is loaded.
- Not defined: 8'h83 is an unknown opcode → ERR; no counters are present.

Decomposition:
- Shared package spi_pkg holds:
  - Opcode localparams (OP_READ_STATUS, OP_READ_BYTES, OP_WRITE_BYTES, OP_READ_STATS).
  - The state enum typedef.
  - FILL_BYTE default.
- No sub-module required; single always_ff FSM plus small output logic. The saturating counter pair may be a tiny sat_cnt module under the macro.

Test Plan:
- STATUS: ing_avail=16, egr_count=3, MOSI 81,00,00 → MISO bytes 2–3 = 8'h10, 8'h03; busy low after byte 3.
- WRITE: MOSI 04,03,AA,BB,CC → exactly 3 ing_push pulses with data AA,BB,CC; state IDLE after.
- READ underrun: egr FIFO holds 11,22; MOSI 82,04,x,x,x,x → MISO payload 11,22,00,00; exactly 2 pops; udf_flag=1.
- WRITE overflow: ing_avail=1; MOSI 04,02,5A,A5 → one push (5A); ovf_flag=1; next STATUS byte-3 bit7=1 and flags cleared after.
- Abort: deassert sel_active after 1 payload byte of WRITE len 4, then a new frame 81 → IDLE, no further pushes, STATUS decodes correctly.
- Unknown opcode 8'h55 then 04,01,77 in the same frame → no push (ERR holds until deselect); with SPI_CMD_STATS_EN, 83 after 2 underruns → MISO 00,02.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared opcodes, FSM state encoding and helpers for the SPI command sequencer.
// The STATS opcode and its states are only decoded when SPI_CMD_STATS_EN is defined.
package spi_pkg;

  localparam logic [7:0] OP_READ_STATUS = 8'h81;
  localparam logic [7:0] OP_READ_BYTES  = 8'h82;
  localparam logic [7:0] OP_WRITE_BYTES = 8'h04;
  localparam logic [7:0] OP_READ_STATS  = 8'h83;

  localparam logic [7:0] FILL_BYTE_DEFAULT = 8'h00;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_STAT0,
    ST_STAT1,
    ST_RLEN,
    ST_RDATA,
    ST_WLEN,
    ST_WDATA,
    ST_ERR,
    ST_STATS0,
    ST_STATS1
  } state_e;

  // Bit 7 of the status byte carries the error flag, so the count keeps 7 bits.
  function automatic logic [6:0] sat7(input logic [7:0] v);
    return v[7] ? 7'h7F : v[6:0];
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/spi_cmd_ctrl.sv
// SPI command sequencer: decodes opcode/length bytes and moves payload between the
// shifter and the ingress/egress byte FIFOs. Define SPI_CMD_STATS_EN for the STATS opcode.
module spi_cmd_ctrl
  import spi_pkg::*;
#(
  parameter int         LEN_W     = 8,
  parameter logic [7:0] FILL_BYTE = FILL_BYTE_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sel_active,
  input  logic       byte_vld,
  input  logic [7:0] byte_rx,
  output logic [7:0] byte_tx,
  output logic [7:0] ing_data,
  output logic       ing_push,
  input  logic [7:0] ing_avail,
  input  logic [7:0] egr_data,
  output logic       egr_pop,
  input  logic [7:0] egr_count,
  output logic       ovf_flag,
  output logic       udf_flag,
  output logic       busy
);

  state_e           state_q;
  logic [LEN_W-1:0] remaining_q;
  logic [7:0]       byte_tx_q;
  logic [7:0]       ing_data_q;
  logic             ing_push_q;
  logic             egr_pop_q;
  logic             ovf_q;
  logic             udf_q;
  logic             stat_flag_q;

  logic [LEN_W-1:0] remaining_d;
  logic [LEN_W-1:0] len_d;
  logic             egr_has;
  logic             ing_has;

  assign remaining_d = remaining_q - LEN_W'(1);
  assign len_d       = LEN_W'(byte_rx);
  assign egr_has     = (egr_count != 8'd0);
  assign ing_has     = (ing_avail != 8'd0);

`ifdef SPI_CMD_STATS_EN
  logic [7:0] ovf_cnt_q;
  logic [7:0] udf_cnt_q;
  logic       drop_evt;
  logic       fill_evt;
  logic       stats_clr;

  assign drop_evt  = sel_active && byte_vld && (state_q == ST_WDATA) && !ing_has;
  assign fill_evt  = sel_active && byte_vld && !egr_has &&
                     (((state_q == ST_RLEN) && (len_d != '0)) ||
                      ((state_q == ST_RDATA) && (remaining_q > LEN_W'(1))));
  assign stats_clr = sel_active && byte_vld && (state_q == ST_STATS0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ovf_cnt_q <= 8'd0;
      udf_cnt_q <= 8'd0;
    end else if (stats_clr) begin
      ovf_cnt_q <= 8'd0;
      udf_cnt_q <= 8'd0;
    end else begin
      if (drop_evt) ovf_cnt_q <= sat_inc8(ovf_cnt_q);
      if (fill_evt) udf_cnt_q <= sat_inc8(udf_cnt_q);
    end
  end
`endif

  // NOTE: all state here uses non-blocking assignments so every register samples the
  // pre-edge values of its peers; blocking would make the result depend on statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      remaining_q <= '0;
      byte_tx_q   <= FILL_BYTE;
      ing_data_q  <= 8'd0;
      ing_push_q  <= 1'b0;
      egr_pop_q   <= 1'b0;
      ovf_q       <= 1'b0;
      udf_q       <= 1'b0;
      stat_flag_q <= 1'b0;
    end else begin
      ing_push_q <= 1'b0;
      egr_pop_q  <= 1'b0;
      if (!sel_active) begin
        // Deselect wins over a coincident byte so an aborted transfer leaves no side effects.
        state_q     <= ST_IDLE;
        remaining_q <= '0;
        byte_tx_q   <= FILL_BYTE;
      end else if (byte_vld) begin
        case (state_q)
          ST_IDLE: begin
            case (byte_rx)
              OP_READ_STATUS: begin
                state_q     <= ST_STAT0;
                byte_tx_q   <= ing_avail;
                stat_flag_q <= ovf_q | udf_q;
                ovf_q       <= 1'b0;
                udf_q       <= 1'b0;
              end
              OP_READ_BYTES:  state_q <= ST_RLEN;
              OP_WRITE_BYTES: state_q <= ST_WLEN;
`ifdef SPI_CMD_STATS_EN
              OP_READ_STATS: begin
                state_q   <= ST_STATS0;
                byte_tx_q <= ovf_cnt_q;
              end
`endif
              default: begin
                state_q   <= ST_ERR;
                byte_tx_q <= FILL_BYTE;
              end
            endcase
          end
          ST_STAT0: begin
            state_q   <= ST_STAT1;
            byte_tx_q <= {stat_flag_q, sat7(egr_count)};
          end
`ifdef SPI_CMD_STATS_EN
          ST_STATS0: begin
            state_q   <= ST_STATS1;
            byte_tx_q <= udf_cnt_q;
          end
`endif
          ST_STAT1, ST_STATS1: begin
            state_q   <= ST_IDLE;
            byte_tx_q <= FILL_BYTE;
          end
          ST_RLEN: begin
            if (len_d == '0) begin
              state_q <= ST_IDLE;
            end else begin
              remaining_q <= len_d;
              state_q     <= ST_RDATA;
              byte_tx_q   <= egr_has ? egr_data : FILL_BYTE;
              egr_pop_q   <= egr_has;
              if (!egr_has) udf_q <= 1'b1;
            end
          end
          ST_RDATA: begin
            remaining_q <= remaining_d;
            if (remaining_q > LEN_W'(1)) begin
              byte_tx_q <= egr_has ? egr_data : FILL_BYTE;
              egr_pop_q <= egr_has;
              if (!egr_has) udf_q <= 1'b1;
            end else begin
              byte_tx_q <= FILL_BYTE;
              state_q   <= ST_IDLE;
            end
          end
          ST_WLEN: begin
            if (len_d == '0) begin
              state_q <= ST_IDLE;
            end else begin
              remaining_q <= len_d;
              state_q     <= ST_WDATA;
            end
          end
          ST_WDATA: begin
            if (ing_has) begin
              ing_data_q <= byte_rx;
              ing_push_q <= 1'b1;
            end else begin
              ovf_q <= 1'b1;
            end
            remaining_q <= remaining_d;
            if (remaining_d == '0) state_q <= ST_IDLE;
          end
          ST_ERR: ;
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign byte_tx  = byte_tx_q;
  assign ing_data = ing_data_q;
  assign ing_push = ing_push_q;
  assign egr_pop  = egr_pop_q;
  assign ovf_flag = ovf_q;
  assign udf_flag = udf_q;
  assign busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_spi_cmd_ctrl.sv
// Scoreboard bench for spi_cmd_ctrl: stimulus queues expected MISO/push bytes,
// monitors compare as the DUT presents them. Honours SPI_CMD_STATS_EN.
module tb_spi_cmd_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       sel_active;
  logic       byte_vld;
  logic [7:0] byte_rx;
  logic [7:0] byte_tx;
  logic [7:0] ing_data;
  logic       ing_push;
  logic [7:0] ing_avail;
  logic [7:0] egr_data;
  logic       egr_pop;
  logic [7:0] egr_count;
  logic       ovf_flag;
  logic       udf_flag;
  logic       busy;

  always #5 clk = ~clk;

  spi_cmd_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .sel_active (sel_active),
    .byte_vld   (byte_vld),
    .byte_rx    (byte_rx),
    .byte_tx    (byte_tx),
    .ing_data   (ing_data),
    .ing_push   (ing_push),
    .ing_avail  (ing_avail),
    .egr_data   (egr_data),
    .egr_pop    (egr_pop),
    .egr_count  (egr_count),
    .ovf_flag   (ovf_flag),
    .udf_flag   (udf_flag),
    .busy       (busy)
  );

  int checks = 0;
  int errors = 0;
  int pushes = 0;
  int pops   = 0;

  logic [7:0] miso_q[$];
  logic [7:0] push_q[$];
  logic [7:0] egr_fifo[$];
  logic [31:0] mon_exp;
  logic [31:0] push_exp;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic refresh_egr();
    egr_count = 8'(egr_fifo.size());
    egr_data  = (egr_fifo.size() != 0) ? egr_fifo[0] : 8'h00;
  endtask

  task automatic load_egr(input logic [7:0] v);
    egr_fifo.push_back(v);
    refresh_egr();
  endtask

  // Monitor: MISO byte of a slot is byte_tx while that slot's byte_vld is high.
  always @(negedge clk) begin
    if (sel_active && byte_vld) begin
      mon_exp = (miso_q.size() != 0) ? {24'h0, miso_q.pop_front()} : 32'h100;
      check("miso", {24'h0, byte_tx}, mon_exp);
    end
    if (ing_push) begin
      pushes++;
      push_exp = (push_q.size() != 0) ? {24'h0, push_q.pop_front()} : 32'h100;
      check("push_data", {24'h0, ing_data}, push_exp);
    end
    if (ing_push || egr_pop) check("push_pop_excl", {31'h0, ing_push & egr_pop}, 32'h0);
  end

  // FIFO models: react to pulses registered at the preceding edge.
  always @(posedge clk) begin
    #1;
    if (egr_pop) begin
      pops++;
      check("pop_nonempty", {31'h0, egr_fifo.size() != 0}, 32'h1);
      if (egr_fifo.size() != 0) void'(egr_fifo.pop_front());
      refresh_egr();
    end
    if (ing_push && ing_avail != 8'd0) ing_avail = ing_avail - 8'd1;
  end

  task automatic send(input logic [7:0] rx, input logic [7:0] exp_miso);
    miso_q.push_back(exp_miso);
    repeat (3) @(posedge clk);
    #1;
    byte_rx  = rx;
    byte_vld = 1'b1;
    @(posedge clk);
    #1;
    byte_vld = 1'b0;
  endtask

  task automatic frame_start();
    @(posedge clk);
    #1 sel_active = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  task automatic frame_end();
    @(posedge clk);
    #1 sel_active = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  int p0;
  int q0;

  initial begin
    reset      = 1'b1;
    sel_active = 1'b0;
    byte_vld   = 1'b0;
    byte_rx    = 8'h00;
    ing_avail  = 8'd0;
    refresh_egr();
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    check("rst_byte_tx", {24'h0, byte_tx}, 32'h00);
    check("rst_ing_push", {31'h0, ing_push}, 32'h0);
    check("rst_egr_pop", {31'h0, egr_pop}, 32'h0);
    check("rst_ing_data", {24'h0, ing_data}, 32'h00);
    check("rst_ovf", {31'h0, ovf_flag}, 32'h0);
    check("rst_udf", {31'h0, udf_flag}, 32'h0);
    check("rst_busy", {31'h0, busy}, 32'h0);

    // STATUS: ing_avail=16, egr_count=3
    ing_avail = 8'd16;
    load_egr(8'hE1); load_egr(8'hE2); load_egr(8'hE3);
    frame_start();
    send(8'h81, 8'h00);
    send(8'h00, 8'h10);
    send(8'h00, 8'h03);
    check("status_busy_after", {31'h0, busy}, 32'h0);
    frame_end();
    egr_fifo.delete();
    refresh_egr();

    // WRITE 3 bytes
    p0 = pushes;
    push_q.push_back(8'hAA); push_q.push_back(8'hBB); push_q.push_back(8'hCC);
    frame_start();
    send(8'h04, 8'h00);
    send(8'h03, 8'h00);
    send(8'hAA, 8'h00);
    send(8'hBB, 8'h00);
    send(8'hCC, 8'h00);
    check("write_busy_after", {31'h0, busy}, 32'h0);
    frame_end();
    check("write_push_count", pushes - p0, 32'd3);

    // WRITE length 0, then a second command in the same frame
    p0 = pushes;
    push_q.push_back(8'h99);
    frame_start();
    send(8'h04, 8'h00);
    send(8'h00, 8'h00);
    check("wlen0_idle", {31'h0, busy}, 32'h0);
    send(8'h04, 8'h00);
    send(8'h01, 8'h00);
    send(8'h99, 8'h00);
    check("wlen1_idle", {31'h0, busy}, 32'h0);
    frame_end();
    check("wlen_push_count", pushes - p0, 32'd1);

    // READ underrun: FIFO holds 11,22, length 4
    load_egr(8'h11); load_egr(8'h22);
    q0 = pops;
    frame_start();
    send(8'h82, 8'h00);
    send(8'h04, 8'h00);
    send(8'h00, 8'h11);
    send(8'h00, 8'h22);
    send(8'h00, 8'h00);
    send(8'h00, 8'h00);
    check("read_busy_after", {31'h0, busy}, 32'h0);
    frame_end();
    check("read_pop_count", pops - q0, 32'd2);
    check("read_udf", {31'h0, udf_flag}, 32'h1);
    check("read_ovf", {31'h0, ovf_flag}, 32'h0);

`ifdef SPI_CMD_STATS_EN
    // STATS after two fill bytes, then again after the counters cleared
    frame_start();
    send(8'h83, 8'h00);
    send(8'h00, 8'h00);
    send(8'h00, 8'h02);
    frame_end();
    frame_start();
    send(8'h83, 8'h00);
    send(8'h00, 8'h00);
    send(8'h00, 8'h00);
    frame_end();
    check("stats_keeps_udf", {31'h0, udf_flag}, 32'h1);
`else
    // Without the stats option 0x83 is an unknown opcode
    p0 = pushes;
    frame_start();
    send(8'h83, 8'h00);
    send(8'h04, 8'h00);
    send(8'h01, 8'h00);
    send(8'h77, 8'h00);
    check("op83_err_busy", {31'h0, busy}, 32'h1);
    frame_end();
    check("op83_no_push", pushes - p0, 32'd0);
`endif

    // WRITE overflow with one free entry
    ing_avail = 8'd1;
    p0 = pushes;
    push_q.push_back(8'h5A);
    frame_start();
    send(8'h04, 8'h00);
    send(8'h02, 8'h00);
    send(8'h5A, 8'h00);
    send(8'hA5, 8'h00);
    frame_end();
    check("ovf_push_count", pushes - p0, 32'd1);
    check("ovf_flag_set", {31'h0, ovf_flag}, 32'h1);
    frame_start();
    send(8'h81, 8'h00);
    send(8'h00, 8'h00);
    send(8'h00, 8'h80);
    frame_end();
    check("status_clr_ovf", {31'h0, ovf_flag}, 32'h0);
    check("status_clr_udf", {31'h0, udf_flag}, 32'h0);
    frame_start();
    send(8'h81, 8'h00);
    send(8'h00, 8'h00);
    send(8'h00, 8'h00);
    frame_end();

    // Abort a WRITE after one payload byte; a byte arriving with deselect is dropped
    ing_avail = 8'd16;
    p0 = pushes;
    push_q.push_back(8'hAB);
    frame_start();
    send(8'h04, 8'h00);
    send(8'h04, 8'h00);
    send(8'hAB, 8'h00);
    @(posedge clk);
    #1;
    sel_active = 1'b0;
    byte_rx    = 8'hCD;
    byte_vld   = 1'b1;
    @(posedge clk);
    #1 byte_vld = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("abort_idle", {31'h0, busy}, 32'h0);
    check("abort_fill", {24'h0, byte_tx}, 32'h00);
    load_egr(8'h33); load_egr(8'h44);
    frame_start();
    send(8'h81, 8'h00);
    send(8'h00, 8'h0F);
    send(8'h00, 8'h02);
    frame_end();
    check("abort_push_count", pushes - p0, 32'd1);
    egr_fifo.delete();
    refresh_egr();

    // Unknown opcode holds ERR until deselect
    p0 = pushes;
    frame_start();
    send(8'h55, 8'h00);
    send(8'h04, 8'h00);
    send(8'h01, 8'h00);
    send(8'h77, 8'h00);
    check("err_busy", {31'h0, busy}, 32'h1);
    frame_end();
    check("err_idle", {31'h0, busy}, 32'h0);
    check("err_no_push", pushes - p0, 32'd0);

    // Maximum length write: 255 bytes, no wrap
    ing_avail = 8'd255;
    p0 = pushes;
    for (int i = 0; i < 255; i++) push_q.push_back(8'(i));
    frame_start();
    send(8'h04, 8'h00);
    send(8'hFF, 8'h00);
    for (int i = 0; i < 255; i++) begin
      send(8'(i), 8'h00);
      if (i == 253) check("len255_busy_before_last", {31'h0, busy}, 32'h1);
    end
    check("len255_idle", {31'h0, busy}, 32'h0);
    frame_end();
    check("len255_push_count", pushes - p0, 32'd255);
    check("len255_ovf", {31'h0, ovf_flag}, 32'h0);

    repeat (5) @(posedge clk);
    check("miso_queue_drained", miso_q.size(), 32'd0);
    check("push_queue_drained", push_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
